// File: rtl/hdlc_pkg.sv
// Shared constants, FSM encoding and CRC step for the HDLC transmit framer.
// The FCS state exists only when HDLC_TX_FCS_EN is defined.
package hdlc_pkg;

    localparam logic [7:0]  FLAG_BYTE = 8'h7E;
    localparam logic [15:0] CRC_POLY  = 16'h8408;
    localparam logic [15:0] CRC_INIT  = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        PAYLOAD  = 3'd2,
`ifdef HDLC_TX_FCS_EN
        FCS      = 3'd3,
`endif
        CLOSE    = 3'd4,
        ABORTSEQ = 3'd5
    } hdlc_state_t;

    // One LSB-first bit of the reflected CRC-16/X.25.
    function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
        logic fb;
        fb = crc[0] ^ b;
        return (crc >> 1) ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/crc16_x25_serial.sv
// Serial CRC-16/X.25 accumulator, one bit per enable; fcs_c is the complemented result.
module crc16_x25_serial
    import hdlc_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        init,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] fcs_c
);

    logic [15:0] crc_q;

    always_ff @(posedge CLK) begin
        if (RST || init) begin
            crc_q <= CRC_INIT;
        end else if (en) begin
            crc_q <= crc_step(crc_q, bit_in);
        end
    end

    assign fcs_c = ~crc_q;

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, bit stuffing, NRZI line coding and underrun abort.
// Define HDLC_TX_FCS_EN to append a CRC-16/X.25 FCS after the payload.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int unsigned BIT_PERIOD = 103,
    parameter int unsigned N_PREAMBLE = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] DATA_IN,
    input  logic       VALID_IN,
    input  logic       LAST_IN,
    output logic       READY_OUT,
    output logic       DET,
    output logic       DATA_out,
    output logic       ABORT
);

    localparam int unsigned CNT_W = $clog2(BIT_PERIOD + 1);

    hdlc_state_t      state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]       sh_q, sh_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [2:0]       ones_q, ones_d;
    logic [4:0]       flag_cnt_q, flag_cnt_d;
    logic             cur_last_q, cur_last_d;
    logic [7:0]       hold_q, hold_d;
    logic             hold_last_q, hold_last_d;
    logic             hold_full_q, hold_full_d;
    logic             ready_q, ready_d;
    logic             det_q, det_d;
    logic             line_q, line_d;
    logic             abort_q, abort_d;

    logic             tick_c, load_c, adv_c, stuff_c, next_bit_c;
    logic             stuff_now_c, stuff_next_c;
    logic [7:0]       load_byte_c;

`ifdef HDLC_TX_FCS_EN
    logic             crc_init_c, crc_en_c;
    logic             fcs_hi_q, fcs_hi_d;
    logic [15:0]      fcs_c;

    crc16_x25_serial u_crc (
        .CLK    (CLK),
        .RST    (RST),
        .init   (crc_init_c),
        .en     (crc_en_c),
        .bit_in (next_bit_c),
        .fcs_c  (fcs_c)
    );
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            sh_q        <= '0;
            bit_idx_q   <= '0;
            ones_q      <= '0;
            flag_cnt_q  <= '0;
            cur_last_q  <= 1'b0;
            hold_q      <= '0;
            hold_last_q <= 1'b0;
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            det_q       <= 1'b0;
            line_q      <= 1'b0;
            abort_q     <= 1'b0;
`ifdef HDLC_TX_FCS_EN
            fcs_hi_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sh_q        <= sh_d;
            bit_idx_q   <= bit_idx_d;
            ones_q      <= ones_d;
            flag_cnt_q  <= flag_cnt_d;
            cur_last_q  <= cur_last_d;
            hold_q      <= hold_d;
            hold_last_q <= hold_last_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            det_q       <= det_d;
            line_q      <= line_d;
            abort_q     <= abort_d;
`ifdef HDLC_TX_FCS_EN
            fcs_hi_q    <= fcs_hi_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        sh_d         = sh_q;
        bit_idx_d    = bit_idx_q;
        ones_d       = ones_q;
        flag_cnt_d   = flag_cnt_q;
        cur_last_d   = cur_last_q;
        hold_d       = hold_q;
        hold_last_d  = hold_last_q;
        hold_full_d  = hold_full_q;
        det_d        = det_q;
        line_d       = line_q;
        abort_d      = 1'b0;
        load_c       = 1'b0;
        adv_c        = 1'b0;
        stuff_c      = 1'b0;
        next_bit_c   = 1'b0;
        stuff_next_c = 1'b0;
        load_byte_c  = FLAG_BYTE;
        tick_c       = (bit_cnt_q == CNT_W'(BIT_PERIOD - 1));
`ifdef HDLC_TX_FCS_EN
        crc_init_c   = 1'b0;
        crc_en_c     = 1'b0;
        fcs_hi_d     = fcs_hi_q;
        stuff_now_c  = (state_q == PAYLOAD) || (state_q == FCS);
`else
        stuff_now_c  = (state_q == PAYLOAD);
`endif

        if (VALID_IN && ready_q) begin
            hold_d      = DATA_IN;
            hold_last_d = LAST_IN;
            hold_full_d = 1'b1;
        end

        if (state_q == IDLE) begin
            if (START) begin
                state_d    = PREAMBLE;
                det_d      = 1'b1;
                flag_cnt_d = '0;
                bit_cnt_d  = '0;
                load_c     = 1'b1;
`ifdef HDLC_TX_FCS_EN
                crc_init_c = 1'b1;
`endif
            end
        end else begin
            bit_cnt_d = tick_c ? '0 : bit_cnt_q + CNT_W'(1);
            if (tick_c) begin
                // Stuff check runs before the byte boundary so trailing ones are covered too.
                if (stuff_now_c && ones_q == 3'd5) begin
                    stuff_c = 1'b1;
                end else if (bit_idx_q != 3'd7) begin
                    adv_c = 1'b1;
                end else begin
                    case (state_q)
                        PREAMBLE, PAYLOAD: begin
                            if (state_q == PREAMBLE && flag_cnt_q != 5'(N_PREAMBLE - 1)) begin
                                flag_cnt_d = flag_cnt_q + 5'd1;
                                load_c     = 1'b1;
                            end else if (state_q == PAYLOAD && cur_last_q) begin
`ifdef HDLC_TX_FCS_EN
                                state_d     = FCS;
                                fcs_hi_d    = 1'b0;
                                load_c      = 1'b1;
                                load_byte_c = fcs_c[7:0];
`else
                                state_d     = CLOSE;
                                load_c      = 1'b1;
`endif
                            end else if (hold_full_q) begin
                                state_d     = PAYLOAD;
                                load_c      = 1'b1;
                                load_byte_c = hold_q;
                                cur_last_d  = hold_last_q;
                                hold_full_d = 1'b0;
                            end else begin
                                state_d     = ABORTSEQ;
                                load_c      = 1'b1;
                                load_byte_c = 8'hFF;
                            end
                        end
`ifdef HDLC_TX_FCS_EN
                        FCS: begin
                            load_c = 1'b1;
                            if (!fcs_hi_q) begin
                                fcs_hi_d    = 1'b1;
                                load_byte_c = fcs_c[15:8];
                            end else begin
                                state_d = CLOSE;
                            end
                        end
`endif
                        CLOSE: begin
                            state_d = IDLE;
                            det_d   = 1'b0;
                        end
                        ABORTSEQ: begin
                            state_d = IDLE;
                            det_d   = 1'b0;
                            abort_d = 1'b1;
                        end
                        default: begin
                            state_d = IDLE;
                            det_d   = 1'b0;
                        end
                    endcase
                end
            end
        end

        // NRZI: a zero toggles the line at the start of its bit period.
        if (stuff_c) begin
            ones_d = '0;
            line_d = ~line_q;
        end else if (load_c || adv_c) begin
`ifdef HDLC_TX_FCS_EN
            stuff_next_c = (state_d == PAYLOAD) || (state_d == FCS);
            crc_en_c     = (state_d == PAYLOAD);
`else
            stuff_next_c = (state_d == PAYLOAD);
`endif
            next_bit_c = load_c ? load_byte_c[0] : sh_q[1];
            sh_d       = load_c ? load_byte_c : (sh_q >> 1);
            bit_idx_d  = load_c ? 3'd0 : bit_idx_q + 3'd1;
            line_d     = next_bit_c ? line_q : ~line_q;
            ones_d     = (stuff_next_c && next_bit_c) ? ones_q + 3'd1 : 3'd0;
        end

        ready_d = !hold_full_d &&
                  (state_d == IDLE || state_d == PREAMBLE || state_d == PAYLOAD);
    end

    assign READY_OUT = ready_q;
    assign DET       = det_q;
    assign DATA_out  = line_q;
    assign ABORT     = abort_q;

endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Directed bench for hdlc_tx_framer: decodes the NRZI line at mid-bit and checks frames.
// Frame-content checks follow the HDLC_TX_FCS_EN setting of the build.
module tb_hdlc_tx_framer;

    localparam int unsigned BP = 103;
    localparam int unsigned NP = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic       START;
    logic [7:0] DATA_IN;
    logic       VALID_IN;
    logic       LAST_IN;
    logic       READY_OUT;
    logic       DET;
    logic       DATA_out;
    logic       ABORT;

    int checks   = 0;
    int failures = 0;

    bit   line_bits[$];
    bit   ds_bits[$];
    int   det_cyc   = 0;
    int   toggles   = 0;
    int   abort_cnt = 0;
    logic prev_lvl  = 1'b0;
    logic last_lvl  = 1'b0;
    logic [63:0] run_a_bits;

    hdlc_tx_framer #(.BIT_PERIOD(BP), .N_PREAMBLE(NP)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .DATA_IN   (DATA_IN),
        .VALID_IN  (VALID_IN),
        .LAST_IN   (LAST_IN),
        .READY_OUT (READY_OUT),
        .DET       (DET),
        .DATA_out  (DATA_out),
        .ABORT     (ABORT)
    );

    always #5 CLK = ~CLK;

    // Line monitor: mid-bit NRZI decode (no change = 1), DET length, toggles, ABORT pulses.
    always @(negedge CLK) begin
        if (DET) begin
            if (det_cyc % int'(BP) == int'(BP / 2)) begin
                line_bits.push_back(bit'(DATA_out == prev_lvl));
                prev_lvl = DATA_out;
            end
            if (DATA_out != last_lvl) toggles++;
            det_cyc++;
        end else begin
            prev_lvl = DATA_out;
        end
        if (ABORT) abort_cnt++;
        last_lvl = DATA_out;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_bits(input int s, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++)
            if (s + i < line_bits.size()) r[i] = line_bits[s + i];
        return r;
    endfunction

    function automatic logic [63:0] ds_get(input int s, input int n);
        logic [63:0] r = '0;
        for (int i = 0; i < n; i++)
            if (s + i < ds_bits.size()) r[i] = ds_bits[s + i];
        return r;
    endfunction

    // Remove the zero that follows every run of five ones.
    task automatic destuff(input int s, input int e);
        int ones = 0;
        ds_bits.delete();
        for (int i = s; i < e; i++) begin
            if (ones == 5 && !line_bits[i]) begin
                ones = 0;
            end else begin
                ds_bits.push_back(line_bits[i]);
                ones = line_bits[i] ? ones + 1 : 0;
            end
        end
    endtask

    task automatic clear_mon();
        line_bits.delete();
        toggles   = 0;
        abort_cnt = 0;
        det_cyc   = 0;
    endtask

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic wait_det(input logic lvl, input int budget, input string tag);
        int n = 0;
        while (DET !== lvl && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check(tag, 64'(DET), 64'(lvl));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input string tag);
        int   n = 0;
        logic rdy;
        DATA_IN  = b;
        LAST_IN  = last;
        VALID_IN = 1'b1;
        while (READY_OUT !== 1'b1 && n < int'(40 * BP)) begin
            @(negedge CLK);
            n++;
        end
        rdy = READY_OUT;
        @(negedge CLK);
        VALID_IN = 1'b0;
        LAST_IN  = 1'b0;
        check(tag, 64'(rdy), 64'd1);
    endtask

    initial begin
        RST      = 1'b1;
        START    = 1'b0;
        DATA_IN  = 8'h00;
        VALID_IN = 1'b0;
        LAST_IN  = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_det",   64'(DET),       64'd0);
        check("rst_line",  64'(DATA_out),  64'd0);
        check("rst_ready", 64'(READY_OUT), 64'd1);
        check("rst_abort", 64'(ABORT),     64'd0);
        RST = 1'b0;
        @(negedge CLK);

`ifndef HDLC_TX_FCS_EN
        // Single 0x00 byte: 4 flags, eight zeros, closing flag.
        clear_mon();
        send_byte(8'h00, 1'b1, "acc_00");
        check("ready_hold_full", 64'(READY_OUT), 64'd0);
        pulse_start();
        wait_det(1'b1, 10, "det_rise_00");
        wait_det(1'b0, int'(60 * BP), "det_fall_00");
        repeat (2) @(negedge CLK);
        check("nbits_00",    64'(line_bits.size()), 64'd48);
        check("preamble_00", get_bits(0, 32), 64'h7E7E7E7E);
        check("payload_00",  get_bits(32, 8), 64'h00);
        check("close_00",    get_bits(40, 8), 64'h7E);
        check("detlen_00",   64'(det_cyc), 64'(6 * 8 * BP));
        check("toggles_00",  64'(toggles), 64'd18);
        check("ready_idle",  64'(READY_OUT), 64'd1);

        // Single 0xFF byte: stuffed zero after the fifth one.
        clear_mon();
        send_byte(8'hFF, 1'b1, "acc_ff");
        pulse_start();
        wait_det(1'b1, 10, "det_rise_ff");
        wait_det(1'b0, int'(60 * BP), "det_fall_ff");
        repeat (2) @(negedge CLK);
        check("nbits_ff",   64'(line_bits.size()), 64'd49);
        check("rawpay_ff",  get_bits(32, 9), 64'h1DF);
        check("close_ff",   get_bits(41, 8), 64'h7E);
        check("detlen_ff",  64'(det_cyc), 64'(49 * BP));
        destuff(32, 41);
        check("dspay_ff",   ds_get(0, 8), 64'hFF);
        check("dslen_ff",   64'(ds_bits.size()), 64'd8);
`endif

        // Underrun at the end of the preamble.
        clear_mon();
        pulse_start();
        wait_det(1'b1, 10, "det_rise_ab");
        wait_det(1'b0, int'(60 * BP), "det_fall_ab");
        repeat (2) @(negedge CLK);
        check("nbits_ab",   64'(line_bits.size()), 64'd40);
        check("ones_ab",    get_bits(32, 8), 64'hFF);
        check("abort_cnt",  64'(abort_cnt), 64'd1);
        check("abort_low",  64'(ABORT), 64'd0);
        check("detlen_ab",  64'(det_cyc), 64'(40 * BP));
        check("toggles_ab", 64'(toggles), 64'd8);
        check("ready_ab",   64'(READY_OUT), 64'd1);

        // Reset in the middle of the payload, then a clean frame.
        clear_mon();
        send_byte(8'h55, 1'b0, "acc_55_rst");
        pulse_start();
        wait_det(1'b1, 10, "det_rise_rst");
        send_byte(8'hAA, 1'b1, "acc_aa_rst");
        repeat (2 * BP) @(negedge CLK);
        check("det_mid", 64'(DET), 64'd1);
        RST = 1'b1;
        @(negedge CLK);
        check("midrst_det",   64'(DET),       64'd0);
        check("midrst_line",  64'(DATA_out),  64'd0);
        check("midrst_ready", 64'(READY_OUT), 64'd1);
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        check("midrst_stay", 64'(DET), 64'd0);

`ifndef HDLC_TX_FCS_EN
        clear_mon();
        send_byte(8'h00, 1'b1, "acc_00_post");
        pulse_start();
        wait_det(1'b1, 10, "det_rise_post");
        wait_det(1'b0, int'(60 * BP), "det_fall_post");
        repeat (2) @(negedge CLK);
        check("nbits_post",   64'(line_bits.size()), 64'd48);
        check("frame_post",   get_bits(0, 48), 64'h7E007E7E7E7E);

        // Two-byte frame, then the same frame with a stray START during the payload.
        clear_mon();
        send_byte(8'h55, 1'b0, "acc_55_a");
        pulse_start();
        wait_det(1'b1, 10, "det_rise_a");
        send_byte(8'hAA, 1'b1, "acc_aa_a");
        wait_det(1'b0, int'(60 * BP), "det_fall_a");
        repeat (2) @(negedge CLK);
        run_a_bits = get_bits(0, 56);
        check("nbits_a",   64'(line_bits.size()), 64'd56);
        check("frame_a",   run_a_bits, 64'h7EAA557E7E7E7E);

        clear_mon();
        send_byte(8'h55, 1'b0, "acc_55_b");
        pulse_start();
        wait_det(1'b1, 10, "det_rise_b");
        send_byte(8'hAA, 1'b1, "acc_aa_b");
        repeat (3 * BP) @(negedge CLK);
        pulse_start();
        wait_det(1'b0, int'(60 * BP), "det_fall_b");
        repeat (10) @(negedge CLK);
        check("nbits_b",    64'(line_bits.size()), 64'd56);
        check("frame_b",    get_bits(0, 56), 64'h7EAA557E7E7E7E);
        check("frame_b_eq", get_bits(0, 56), run_a_bits);
        check("detlen_b",   64'(det_cyc), 64'(56 * BP));
        check("no_restart", 64'(DET), 64'd0);
`else
        // "123456789" with FCS: check value 0x906E, sent low byte first.
        clear_mon();
        send_byte(8'h31, 1'b0, "acc_fcs_1");
        pulse_start();
        wait_det(1'b1, 10, "det_rise_fcs");
        for (int i = 2; i <= 9; i++)
            send_byte(8'(8'h30 + i), 1'(i == 9), "acc_fcs_n");
        wait_det(1'b0, int'(100 * BP), "det_fall_fcs");
        repeat (2) @(negedge CLK);
        check("nbits_fcs",   64'(line_bits.size()), 64'd128);
        check("pre_fcs",     get_bits(0, 32), 64'h7E7E7E7E);
        check("close_fcs",   get_bits(120, 8), 64'h7E);
        destuff(32, line_bits.size() - 8);
        check("dslen_fcs",   64'(ds_bits.size()), 64'd88);
        check("first_fcs",   ds_get(0, 8), 64'h31);
        check("fcs_lo",      ds_get(72, 8), 64'h6E);
        check("fcs_hi",      ds_get(80, 8), 64'h90);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
